i2s_rx_tdm_channel: RTL
=======================

# i2s_rx_tdm_channel

Parametrised multi-lane TDM/DSP-mode I2S receiver. Successor to the 2-channel DSP receive channel: generalised to NUM_LANES serial data pins, up to MAX_SLOTS time slots per frame and any word length 1–32 bits (LSB-first included), with a tagged output FIFO and overflow/frame-error reporting. Sits in the I2S slave path between the pads (sck/ws/sd) and the uDMA RX data path, clocked by the bit clock.

## Interface
- NUM_LANES, 2: serial data inputs sampled in parallel (1–4).
- MAX_SLOTS, 8: maximum slots per frame (power of 2, 2–16); SLOT_W = $clog2(MAX_SLOTS).
- FIFO_DEPTH, 4: output FIFO entries (power of 2, ≥2).
- sck_i  in  1  bit clock; only clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- sd_i  in  NUM_LANES  serial data, one bit per lane.
- ws_i  in  1  frame sync; frame starts on sampled 0→1 transition.
- cfg_en_i  in  1  enable; config inputs only change while low.
- cfg_lane_en_i  in  NUM_LANES  per-lane capture enable.
- cfg_num_bits_i  in  5  word length minus 1.
- cfg_num_slots_i  in  SLOT_W  slots per frame minus 1.
- cfg_lsb_first_i  in  1  1 = first bit received is LSB.
- cfg_offset_i  in  9  bit clocks from sync edge to first data bit.
- cfg_continuous_i  in  1  1 = run until disabled; 0 = one-shot.
- cfg_num_frames_i  in  8  one-shot frame count minus 1.
- data_o  out  32  received word, right-justified, upper bits zero.
- data_lane_o  out  $clog2(NUM_LANES) (min 1)  lane tag of data_o.
- data_slot_o  out  SLOT_W  slot tag of data_o.
- data_valid_o  out  1  FIFO head valid.
- data_ready_i  in  1  consumer accepts head.
- err_o  out  1  one-cycle pulse per overflow or frame error.
- done_o  out  1  one-cycle pulse at one-shot completion.
- busy_o  out  1  high in ARMED, OFFSET, RUN.

## Operation
- ws_q = ws_i registered; sync = ws_i & ~ws_q.
- States: IDLE, ARMED, OFFSET, RUN, DONE.
- IDLE: cfg_en_i=1 → ARMED. Counters cleared.
- ARMED: on sync, offset=0 → bit 0 of slot 0 sampled that cycle, go RUN; offset≠0 → OFFSET, offset counter = 1.
- OFFSET: counter increments each cycle; cycle where counter == cfg_offset_i samples bit 0 of slot 0, go RUN. First bit sampled exactly cfg_offset_i cycles after sync cycle.
- RUN: one bit per cycle per enabled lane; bit counter 0..cfg_num_bits_i, then slot counter increments; after bit cfg_num_bits_i of slot cfg_num_slots_i: frame complete → ARMED (continuous, or frames remaining) or DONE (one-shot, frame count reached, done_o pulse).
- sync during RUN or OFFSET (frame not complete): frame error, err_o pulse, partial words dropped, frame restarts from this edge exactly as in ARMED.
- DONE: holds until cfg_en_i=0 → IDLE; no further capture.
- cfg_en_i=0 in any state → IDLE next cycle; in-progress words dropped; FIFO and shadow contents retained and drained.
- Assembly: MSB-first shifts left inserting at bit 0. LSB-first shifts right inserting at bit 31; at completion word is shifted right by 31−cfg_num_bits_i. Result identical alignment for any length 1–32.
- Completion: on the last-bit cycle each enabled lane's word goes to a per-lane shadow register with tag {lane, slot}. Shadows drain into the FIFO one per cycle, lowest lane first.
- Overflow: word completes while its lane's shadow is still occupied → new word dropped, err_o pulse, capture continues.
- FIFO: first-word-fall-through; pop on data_valid_o & data_ready_i; push into full FIFO allowed only when popping in the same cycle; otherwise shadow holds.

## Timing
- Reset: state IDLE, FIFO empty, shadows empty; data_o, tags, data_valid_o, err_o, done_o, busy_o all 0.
- Latency: last bit sampled at edge E → lane k word in FIFO at edge E+1+k; data_valid_o high after E+1 for lane 0 (FIFO empty, ready high).
- Back-to-back frames with zero gap supported: sync detected in ARMED in the first cycle after frame completion.
- Sustained throughput requires cfg_num_bits_i+1 ≥ number of enabled lanes.
- err_o and done_o never high for more than one cycle per event; frame-error and overflow in the same cycle give one pulse.

## Test plan
- Reset with ws_i toggling, rst_i held 4 cycles → all outputs 0, no FIFO writes.
- 2 lanes, 16-bit MSB-first, 4 slots, offset 1, continuous; lane0 slots 0x1234,0x5678,0x9ABC,0xDEF0 → 8 words in order lane0/lane1 per slot, correct tags, data_valid_o at E+1.
- 1 lane, 24-bit LSB-first (cfg_num_bits_i=23), offset 0; send 0xA5C33C → data_o = 0x00A5C33C.
- One-shot, cfg_num_frames_i=2, 2 slots → exactly 3 frames captured, done_o pulses once, state DONE until cfg_en_i low.
- data_ready_i held 0, FIFO_DEPTH=4, 2 lanes 8-bit → FIFO fills, shadows hold, next completion drops words, err_o pulse per event; release ready → 4+2 stored words emerge intact.
- sync mid-slot 1 → err_o pulse, partial word not output, new frame captured correctly from that edge.

Source files
------------

// File: rtl/i2s_rx_tdm_channel_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_tdm_channel_if
// Brief    : Tagged receive-word stream from the TDM receiver to its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface i2s_rx_tdm_channel_if #(
    parameter int NUM_LANES = 2,
    parameter int MAX_SLOTS = 8
);
    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int SLOT_W = $clog2(MAX_SLOTS);

    logic [31:0]       data_o;
    logic [LANE_W-1:0] data_lane_o;
    logic [SLOT_W-1:0] data_slot_o;
    logic              data_valid_o;
    logic              data_ready_i;

    modport master (
        output data_o, data_lane_o, data_slot_o, data_valid_o,
        input  data_ready_i
    );

    modport slave (
        input  data_o, data_lane_o, data_slot_o, data_valid_o,
        output data_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/i2s_rx_tdm_channel.sv
`default_nettype none
// ============================================================================
// Module   : i2s_rx_tdm_channel
// Brief    : Multi-lane TDM/DSP-mode I2S receiver with tagged FWFT output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_rx_tdm_channel #(
    parameter int NUM_LANES  = 2,
    parameter int MAX_SLOTS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  wire                         sck_i,
    input  wire                         rst_i,
    input  wire [NUM_LANES-1:0]         sd_i,
    input  wire                         ws_i,
    input  wire                         cfg_en_i,
    input  wire [NUM_LANES-1:0]         cfg_lane_en_i,
    input  wire [4:0]                   cfg_num_bits_i,
    input  wire [$clog2(MAX_SLOTS)-1:0] cfg_num_slots_i,
    input  wire                         cfg_lsb_first_i,
    input  wire [8:0]                   cfg_offset_i,
    input  wire                         cfg_continuous_i,
    input  wire [7:0]                   cfg_num_frames_i,
    i2s_rx_tdm_channel_if.master        rx_if,
    output logic                        err_o,
    output logic                        done_o,
    output logic                        busy_o
);
    localparam int SLOT_W  = $clog2(MAX_SLOTS);
    localparam int LANE_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = LANE_W + SLOT_W + 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_OFFSET = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_ws_q, w_sync, w_restart;
    logic [8:0]          r_off_cnt, w_off_cnt_nxt;
    logic [4:0]          r_bit_cnt, w_bit_cnt_nxt, w_cur_bit;
    logic [SLOT_W-1:0]   r_slot_cnt, w_slot_cnt_nxt, w_cur_slot;
    logic [7:0]          r_frame_cnt, w_frame_cnt_nxt;
    logic                w_sample, w_first, w_last_bit, w_frame_end, w_complete;
    logic                w_frame_err, w_done, w_ovf, r_err, r_done;

    logic [31:0]         r_shift     [NUM_LANES];
    logic [31:0]         w_base      [NUM_LANES];
    logic [31:0]         w_shift_nxt [NUM_LANES];
    logic [31:0]         w_word      [NUM_LANES];
    logic [NUM_LANES-1:0] r_sh_valid, w_load, w_drain;
    logic [31:0]         r_sh_data   [NUM_LANES];
    logic [SLOT_W-1:0]   r_sh_slot   [NUM_LANES];
    logic [LANE_W-1:0]   w_drain_idx;
    logic                w_found, w_push, w_pop, w_full, w_empty;
    logic [ENTRY_W-1:0]  w_push_entry, w_head;
    logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W:0]      r_wr_ptr, r_rd_ptr;

    assign w_sync = ws_i & ~r_ws_q;

    always_comb begin
        w_state_nxt     = r_state;
        w_off_cnt_nxt   = r_off_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_slot_cnt_nxt  = r_slot_cnt;
        w_frame_cnt_nxt = r_frame_cnt;
        w_sample        = 1'b0;
        w_first         = 1'b0;
        w_restart       = 1'b0;
        w_frame_err     = 1'b0;
        w_done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_off_cnt_nxt   = '0;
                w_bit_cnt_nxt   = '0;
                w_slot_cnt_nxt  = '0;
                w_frame_cnt_nxt = '0;
                if (cfg_en_i) w_state_nxt = S_ARMED;
            end
            S_ARMED: w_restart = w_sync;
            S_OFFSET: begin
                if (w_sync) begin
                    w_restart   = 1'b1;
                    w_frame_err = 1'b1;
                end else if (r_off_cnt == cfg_offset_i) begin
                    w_sample = 1'b1;
                    w_first  = 1'b1;
                end else begin
                    w_off_cnt_nxt = r_off_cnt + 9'd1;
                end
            end
            S_RUN: begin
                if (w_sync) begin
                    w_restart   = 1'b1;
                    w_frame_err = 1'b1;
                end else begin
                    w_sample = 1'b1;
                end
            end
            default: ;
        endcase
        // A sync edge (fresh or mid-frame) always restarts slot 0 from this cycle.
        if (w_restart) begin
            if (cfg_offset_i == 9'd0) begin
                w_sample = 1'b1;
                w_first  = 1'b1;
            end else begin
                w_state_nxt   = S_OFFSET;
                w_off_cnt_nxt = 9'd1;
            end
        end
        w_cur_bit   = w_first ? 5'd0 : r_bit_cnt;
        w_cur_slot  = w_first ? '0 : r_slot_cnt;
        w_last_bit  = (w_cur_bit == cfg_num_bits_i);
        w_frame_end = w_last_bit && (w_cur_slot == cfg_num_slots_i);
        if (w_sample) begin
            w_state_nxt = S_RUN;
            if (w_last_bit) begin
                w_bit_cnt_nxt  = 5'd0;
                w_slot_cnt_nxt = w_cur_slot + 1'b1;
            end else begin
                w_bit_cnt_nxt  = w_cur_bit + 5'd1;
                w_slot_cnt_nxt = w_cur_slot;
            end
            if (w_frame_end) begin
                w_slot_cnt_nxt = '0;
                if (cfg_continuous_i || (r_frame_cnt != cfg_num_frames_i)) begin
                    w_state_nxt     = S_ARMED;
                    w_frame_cnt_nxt = r_frame_cnt + 8'd1;
                end else begin
                    w_state_nxt = S_DONE;
                    w_done      = 1'b1;
                end
            end
        end
        if (!cfg_en_i) begin
            w_state_nxt = S_IDLE;
            w_sample    = 1'b0;
            w_first     = 1'b0;
            w_frame_err = 1'b0;
            w_done      = 1'b0;
        end
        w_complete = w_sample & w_last_bit;
    end

    // LSB-first words build from bit 31 down, so realign once complete.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            w_base[l]      = (w_cur_bit == 5'd0) ? 32'd0 : r_shift[l];
            w_shift_nxt[l] = cfg_lsb_first_i ? {sd_i[l], w_base[l][31:1]}
                                             : {w_base[l][30:0], sd_i[l]};
            w_word[l]      = cfg_lsb_first_i ? (w_shift_nxt[l] >> (5'd31 - cfg_num_bits_i))
                                             : w_shift_nxt[l];
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop   = ~w_empty & rx_if.data_ready_i;

    always_comb begin
        w_found     = 1'b0;
        w_drain_idx = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (r_sh_valid[l] && !w_found) begin
                w_found     = 1'b1;
                w_drain_idx = LANE_W'(l);
            end
        end
        w_push  = w_found & (~w_full | w_pop);
        w_drain = '0;
        if (w_push) w_drain[w_drain_idx] = 1'b1;
        w_push_entry = {w_drain_idx, r_sh_slot[w_drain_idx], r_sh_data[w_drain_idx]};
        // A shadow emptying this cycle can take the new word.
        w_load = {NUM_LANES{w_complete}} & cfg_lane_en_i & (~r_sh_valid | w_drain);
        w_ovf  = |({NUM_LANES{w_complete}} & cfg_lane_en_i & r_sh_valid & ~w_drain);
    end

    always_ff @(posedge sck_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_ws_q      <= 1'b0;
            r_off_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_slot_cnt  <= '0;
            r_frame_cnt <= '0;
            r_sh_valid  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ws_q      <= ws_i;
            r_off_cnt   <= w_off_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_slot_cnt  <= w_slot_cnt_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
            r_sh_valid  <= (r_sh_valid & ~w_drain) | w_load;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_err       <= w_frame_err | w_ovf;
            r_done      <= w_done;
        end
    end

    always_ff @(posedge sck_i) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (w_sample) r_shift[l] <= w_shift_nxt[l];
            if (w_load[l]) begin
                r_sh_data[l] <= w_word[l];
                r_sh_slot[l] <= w_cur_slot;
            end
        end
        if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= w_push_entry;
    end

    assign w_head             = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign rx_if.data_valid_o = ~w_empty;
    assign rx_if.data_o       = w_empty ? 32'd0 : w_head[31:0];
    assign rx_if.data_slot_o  = w_empty ? '0 : w_head[32 +: SLOT_W];
    assign rx_if.data_lane_o  = w_empty ? '0 : w_head[32+SLOT_W +: LANE_W];

    assign err_o  = r_err;
    assign done_o = r_done;
    assign busy_o = (r_state == S_ARMED) || (r_state == S_OFFSET) || (r_state == S_RUN);
endmodule
`default_nettype wire
